// File: rtl/ror_arbiter.sv
// Round-robin arbiter and two-stage pipeline sharing one 64-bit rotate-right shifter.
// Optional ROR_ARB_PRIO0_EN: requester 0 has fixed top priority, the rest rotate.
module ror_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 64,
  parameter int SHW   = 6,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ*SHW-1:0]   req_shamt,
  output logic [WIDTH-1:0]       sh_in,
  output logic [SHW-1:0]         sh_amt,
  input  logic [WIDTH-1:0]       sh_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id
);

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [SHW-1:0]   amt_arr  [N_REQ];
  logic [N_REQ-1:0] rr_valid;
  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   ptr_next;
  logic [IDW-1:0]   win_idx;
  logic             win_found;
  logic             grant_ok;
  logic             ptr_load;
  logic             b_adv;
  logic             a_adv;
  logic             a_free;
  int               idx;

  logic             a_valid_reg;
  logic [WIDTH-1:0] a_data_reg;
  logic [SHW-1:0]   a_amt_reg;
  logic [IDW-1:0]   a_id_reg;
  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [IDW-1:0]   rsp_id_reg;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*WIDTH +: WIDTH];
      assign amt_arr[gi]   = req_shamt[gi*SHW +: SHW];
      assign req_ready[gi] = grant_ok && (win_idx == IDW'(gi));
    end
  endgenerate

  assign b_adv  = !rsp_valid_reg || rsp_ready;
  assign a_adv  = a_valid_reg && b_adv;
  assign a_free = !a_valid_reg || b_adv;

`ifdef ROR_ARB_PRIO0_EN
  // Requester 0 is handled outside the rotation, so the pointer never selects it.
  assign rr_valid = {req_valid[N_REQ-1:1], 1'b0};
`else
  assign rr_valid = req_valid;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && rr_valid[IDW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
`ifdef ROR_ARB_PRIO0_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  assign grant_ok = win_found && a_free && !rst;

`ifdef ROR_ARB_PRIO0_EN
  assign ptr_load = grant_ok && (win_idx != '0);
`else
  assign ptr_load = grant_ok;
`endif

  always_comb begin
    ptr_next = ptr_reg;
    if (ptr_load) ptr_next = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
  end

  // A refills in the same cycle it hands off to B, giving one op per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      a_valid_reg   <= 1'b0;
      a_data_reg    <= '0;
      a_amt_reg     <= '0;
      a_id_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (grant_ok) begin
        a_valid_reg <= 1'b1;
        a_data_reg  <= data_arr[win_idx];
        a_amt_reg   <= amt_arr[win_idx];
        a_id_reg    <= win_idx;
      end else if (a_adv) begin
        a_valid_reg <= 1'b0;
      end
      if (a_adv) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= sh_result;
        rsp_id_reg    <= a_id_reg;
      end else if (b_adv) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign sh_in     = a_data_reg;
  assign sh_amt    = a_amt_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_ror_arbiter.sv
// Bench for ror_arbiter: directed scenarios plus a randomised run, checked by a response scoreboard.
// Build with ROR_ARB_PRIO0_EN defined to check the fixed-priority variant.
module tb_ror_arbiter;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int S   = 6;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_data;
  logic [N*S-1:0]   req_shamt;
  logic [W-1:0]     sh_in;
  logic [S-1:0]     sh_amt;
  logic [W-1:0]     sh_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [IDW-1:0]   rsp_id;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_rsp = 0;
  exp_t sb[$];

  ror_arbiter #(.N_REQ(N), .WIDTH(W), .SHW(S), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shamt(req_shamt), .sh_in(sh_in), .sh_amt(sh_amt),
    .sh_result(sh_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  // Shared shifter stand-in.
  logic [2*W-1:0] dbl;
  always_comb begin
    dbl       = {sh_in, sh_in} >> sh_amt;
    sh_result = dbl[W-1:0];
  end

  function automatic logic [W-1:0] ref_ror(input logic [W-1:0] x, input int s);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) r[b] = x[(b + s) % W];
    return r;
  endfunction

  // Handshakes are sampled on the falling edge; they take effect on the next rising edge.
  logic           hold = 1'b0;
  logic [W-1:0]   hold_data;
  logic [IDW-1:0] hold_id;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_data !== hold_data || rsp_id !== hold_id) begin
          n_err++;
          $display("FAIL rsp_stable got v=%b id=%0d data=%h want v=1 id=%0d data=%h",
                   rsp_valid, rsp_id, rsp_data, hold_id, hold_data);
        end
      end
      n_vec++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
        n_err++;
        $display("FAIL req_ready_onehot got=%b valid=%b want one-hot subset", req_ready, req_valid);
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected got id=%0d data=%h want no response", rsp_id, rsp_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            n_err++;
            $display("FAIL sb_rsp got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
          end else begin
            $display("rsp id=%0d data=%h ok", rsp_id, rsp_data);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.id   = IDW'(i);
          e.data = ref_ror(req_data[i*W +: W], int'(req_shamt[i*S +: S]));
          sb.push_back(e);
        end
      end
      hold      = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
      hold_id   = rsp_id;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [S-1:0] a);
    req_data[i*W +: W]  = d;
    req_shamt[i*S +: S] = a;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    logic [N-1:0] acc;
    int c;
    rsp_ready = 1'b1;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_valid == '0 && sb.size() == 0 && !rsp_valid) break;
      acc = req_valid & req_ready;
      step();
      req_valid &= ~acc;
    end
    n_vec++;
    if (c >= 50) begin
      n_err++;
      $display("FAIL drain_timeout got pending=%0d want 0 within 50 cycles", sb.size());
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, S'(i + 1));
    req_valid = '1;
    step();
    step();
    @(negedge clk);
    n_vec++;
    if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_vec++;
    if (rsp_data !== '0 || rsp_id !== '0) begin
      n_err++; $display("FAIL reset_rsp_data got id=%0d data=%h want 0", rsp_id, rsp_data);
    end
    n_vec++;
    if (sh_in !== '0 || sh_amt !== '0) begin
      n_err++; $display("FAIL reset_stage_a got in=%h amt=%0d want 0", sh_in, sh_amt);
    end
    step();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_req(2, 64'h0000_0000_0000_0001, 6'd1);
    req_valid = 4'b0100;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant got=%b want=0100", req_ready); end
    step();
    req_valid = '0;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early got v=%b want 0", rsp_valid); end
    step();
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h8000_0000_0000_0000 || rsp_id !== 2'd2) begin
      n_err++;
      $display("FAIL single_rsp got v=%b id=%0d data=%h want v=1 id=2 data=8000000000000000",
               rsp_valid, rsp_id, rsp_data);
    end
    step();
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_after got v=%b want 0", rsp_valid); end
    step();
  endtask

  task automatic test_shamt();
    logic [S-1:0] amt_tab [3] = '{6'd0, 6'd63, 6'd32};
    logic [W-1:0] exp_tab [3] = '{64'h0123_4567_89AB_CDEF, 64'h0246_8ACF_1357_9BDE, 64'h89AB_CDEF_0123_4567};
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(1, 64'h0123_4567_89AB_CDEF, amt_tab[k]);
      req_valid = 4'b0010;
      @(negedge clk);
      n_vec++;
      if (req_ready !== 4'b0010) begin n_err++; $display("FAIL shamt_grant got=%b want=0010", req_ready); end
      step();
      req_valid = '0;
      step();
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_tab[k] || rsp_id !== 2'd1) begin
        n_err++;
        $display("FAIL shamt_%0d got v=%b id=%0d data=%h want v=1 id=1 data=%h",
                 amt_tab[k], rsp_valid, rsp_id, rsp_data, exp_tab[k]);
      end
      step();
    end
  endtask

  task automatic test_fairness();
    int got[$];
    int first;
    int bubbles;
    int exp_id;
    pulse_reset();
    for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, S'(i * 5));
    rsp_ready = 1'b1;
    req_valid = '1;
    first = -1;
    bubbles = 0;
    for (int c = 0; c < 20 && got.size() < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (first < 0) first = c;
        got.push_back(int'(rsp_id));
      end else if (got.size() > 0) begin
        bubbles++;
      end
      step();
    end
    n_vec++;
    if (got.size() != 8 || first != 2 || bubbles != 0) begin
      n_err++;
      $display("FAIL fair_stream got n=%0d first=%0d bubbles=%0d want n=8 first=2 bubbles=0",
               got.size(), first, bubbles);
    end
    for (int k = 0; k < got.size(); k++) begin
`ifdef ROR_ARB_PRIO0_EN
      exp_id = 0;
`else
      exp_id = k % N;
`endif
      n_vec++;
      if (got[k] != exp_id) begin
        n_err++; $display("FAIL fair_id[%0d] got=%0d want=%0d", k, got[k], exp_id);
      end
    end
    req_valid = '0;
    drain();
  endtask

  task automatic test_backpressure();
    logic [N-1:0]   acc;
    int             grants[$];
    int             rids[$];
    logic [W-1:0]   held_data;
    logic [IDW-1:0] held_id;
    int             first;
    int             last;
    pulse_reset();
    for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, S'($urandom_range(0, 63)));
    rsp_ready = 1'b0;
    req_valid = '1;
    held_data = '0;
    held_id = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) if (acc[i]) grants.push_back(i);
      if (c == 2) begin held_data = rsp_data; held_id = rsp_id; end
      if (c == 4) begin
        n_vec++;
        if (req_ready !== '0) begin n_err++; $display("FAIL bp_full_ready got=%b want=0000", req_ready); end
        n_vec++;
        if (rsp_data !== held_data || rsp_id !== held_id) begin
          n_err++;
          $display("FAIL bp_hold got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, held_id, held_data);
        end
      end
      step();
      req_valid &= ~acc;
    end
    n_vec++;
    if (grants.size() != 2) begin n_err++; $display("FAIL bp_accepts got=%0d want=2", grants.size()); end
    rsp_ready = 1'b1;
    first = -1;
    last = -1;
    for (int c = 0; c < 12 && rids.size() < 4; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) if (acc[i]) grants.push_back(i);
      if (rsp_valid) begin
        if (first < 0) first = c;
        last = c;
        rids.push_back(int'(rsp_id));
      end
      step();
      req_valid &= ~acc;
    end
    n_vec++;
    if (grants.size() != 4 || rids.size() != 4 || last - first != 3) begin
      n_err++;
      $display("FAIL bp_release got grants=%0d rsps=%0d span=%0d want 4 4 3",
               grants.size(), rids.size(), last - first);
    end
    for (int k = 0; k < 4 && k < grants.size() && k < rids.size(); k++) begin
      n_vec++;
      if (grants[k] != k || rids[k] != k) begin
        n_err++; $display("FAIL bp_order[%0d] got grant=%0d rsp=%0d want %0d", k, grants[k], rids[k], k);
      end
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] acc;
    logic [W-1:0] exp0;
    pulse_reset();
    for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, S'($urandom_range(0, 63)));
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      req_valid &= ~acc;
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== '0) begin n_err++; $display("FAIL mid_rst_ready got=%b want=0000", req_ready); end
    step();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      n_err++; $display("FAIL mid_after got v=%b ready=%b want v=0 ready=0000", rsp_valid, req_ready);
    end
    step();
    exp0 = ref_ror(req_data[0 +: W], int'(req_shamt[0 +: S]));
    req_valid = '1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr got=%b want=0001", req_ready); end
    acc = req_valid & req_ready;
    step();
    req_valid &= ~acc;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_early got v=%b want 0", rsp_valid); end
    acc = req_valid & req_ready;
    step();
    req_valid &= ~acc;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp0) begin
      n_err++;
      $display("FAIL mid_first got v=%b id=%0d data=%h want v=1 id=0 data=%h", rsp_valid, rsp_id, rsp_data, exp0);
    end
    step();
    drain();
  endtask

  task automatic test_random();
    logic [N-1:0] acc;
    int n_acc;
    int rsp0;
    n_acc = 0;
    rsp0 = n_rsp;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      n_acc += $countones(acc);
      step();
      req_valid &= ~acc;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          set_req(i, {$urandom, $urandom}, S'($urandom_range(0, 63)));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc = req_valid & req_ready;
    n_acc += $countones(acc);
    step();
    req_valid &= ~acc;
    // Pending requesters are still accepted during the drain; count them there.
    begin
      int c;
      rsp_ready = 1'b1;
      for (c = 0; c < 50; c++) begin
        @(negedge clk);
        if (req_valid == '0 && sb.size() == 0 && !rsp_valid) break;
        acc = req_valid & req_ready;
        n_acc += $countones(acc);
        step();
        req_valid &= ~acc;
      end
      n_vec++;
      if (c >= 50) begin n_err++; $display("FAIL rand_drain got pending=%0d want 0", sb.size()); end
      step();
    end
    n_vec++;
    if (n_rsp - rsp0 != n_acc) begin
      n_err++; $display("FAIL rand_count got rsps=%0d want accepts=%0d", n_rsp - rsp0, n_acc);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_data = '0;
    req_shamt = '0;
    #1;
    test_reset();
    test_single();
    test_shamt();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ror_arbiter.md
# ror_arbiter

Round-robin arbiter and two-stage pipeline controller that shares one combinational 64-bit rotate-right shifter among `N_REQ` requesters. Each requester presents an operand and shift amount over a valid/ready handshake. The block registers the winning operation, drives the shared shifter, and returns the result tagged with the requester index over a valid/ready response port. It sits between the execution-unit issue logic and the shifter instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 64: operand width; fixed to 64 to match the shifter.
- `SHW`, 6: shift-amount width; fixed to log2(`WIDTH`).
- `IDW`, `$clog2(N_REQ)`: response tag width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept; one-hot or zero.
- `req_data`  in  `N_REQ*WIDTH`  operands; requester i at `[i*WIDTH +: WIDTH]`.
- `req_shamt`  in  `N_REQ*SHW`  rotate amounts; requester i at `[i*SHW +: SHW]`.
- `sh_in`  out  `WIDTH`  operand to the shared shifter.
- `sh_amt`  out  `SHW`  shift amount to the shared shifter.
- `sh_result`  in  `WIDTH`  combinational rotate-right result from the shifter.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  `WIDTH`  rotated result.
- `rsp_id`  out  `IDW`  index of the originating requester.

## Operation
- Pipeline stage A holds the operand register: `a_valid`, `a_data`, `a_amt`, `a_id`.
  - `sh_in = a_data` and `sh_amt = a_amt`, driven continuously.
- Pipeline stage B holds the output register: `rsp_valid`, `rsp_data`, `rsp_id`.
- Per-stage state is EMPTY/FULL (the valid bit).
- Advance conditions:
  - `b_adv = !rsp_valid || rsp_ready`.
  - `a_adv = a_valid && b_adv`.
  - `a_free = !a_valid || b_adv`.
- Arbitration (combinational):
  - When `a_free`, search `req_valid` starting at pointer `ptr` and wrapping upward.
  - The first set bit wins; `req_ready[win]=1`.
  - When `!a_free` or no request is pending, `req_ready=0`.
- Accept (`req_valid[i] && req_ready[i]`):
  - Load A with requester i's data, shamt and id.
  - Set `ptr <= (i+1) mod N_REQ`.
  - `ptr` is unchanged when nothing is accepted.
- On `a_adv`: `rsp_data <= sh_result`, `rsp_id <= a_id`, `rsp_valid <= 1`.
- On `b_adv && !a_adv`: `rsp_valid <= 0`.
- A clears when it advances with no new accept.
- Simultaneous accept into A and A→B transfer in the same cycle is the normal full-throughput case.
- Requesters hold `req_valid`, data and shamt stable until accepted. The arbiter never drops an accepted request.
- The shift amount is used modulo 64 as-is. Amount 0 passes the operand unchanged; amount 63 equals rotate-left by 1.
- Reset values:
  - `rsp_valid=0`, `a_valid=0`, `ptr=0`, `rsp_data=0`, `rsp_id=0`, `a_data=0`, `a_amt=0`, `a_id=0`.
  - `req_ready=0` during the reset cycle.
- Reset mid-operation discards the contents of A and B without emitting them.

## Timing
- Latency: request accepted at edge T produces `rsp_valid=1` with the result after edge T+1. This is 2 cycles from the accepting cycle to response visible.
- Throughput: 1 operation per cycle with `rsp_ready` held high.
- Backpressure: with `rsp_ready=0`, at most 2 operations are held (A and B). `req_ready` is all-zero while both stages are FULL.
- `rsp_valid`, `rsp_data` and `rsp_id` are stable while `rsp_valid && !rsp_ready`.
- `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`. No other input-to-output combinational paths exist besides `sh_result`→A→B.

## Configuration
- `ROR_ARB_PRIO0_EN`:
  - Defined: requester 0 has fixed highest priority; when `req_valid[0]` and `a_free`, requester 0 wins regardless of `ptr`. Requesters 1..N_REQ-1 round-robin among themselves via `ptr`, which skips index 0.
  - Undefined: pure round-robin across all requesters as described above.

## Test plan
- Single request: requester 2, data `0x0000_0000_0000_0001`, shamt 1, `rsp_ready=1` → one cycle later `rsp_valid=1`, `rsp_data=0x8000_0000_0000_0000`, `rsp_id=2`; `rsp_valid=0` the following cycle.
- Boundary shamts: data `0x0123_4567_89AB_CDEF` with shamt 0 → `0x0123_4567_89AB_CDEF`; with shamt 63 → `0x0246_8ACF_1357_9BDE`; with shamt 32 → `0x89AB_CDEF_0123_4567`.
- Fairness: all four `req_valid=1` continuously, `rsp_ready=1`, macro off → `rsp_id` sequence 0,1,2,3,0,1,2,3 on consecutive cycles. Macro on → `rsp_id` is 0 every cycle.
- Backpressure: 4 requests pending, `rsp_ready=0` for 5 cycles → exactly 2 accepts, then `req_ready=0`; `rsp_data/rsp_id` stay stable. Releasing `rsp_ready` → remaining results arrive at 1 per cycle in grant order, with no loss or duplication.
- Reset mid-flight: with A and B FULL, assert `rst` for 1 cycle → next cycle `rsp_valid=0`, `ptr=0`, `req_ready=0`. The first post-reset request from requester 0 completes with a 2-cycle latency.
- Randomised valid/ready on all ports for 10,000 cycles against a reference rotate model → every accepted operation is returned exactly once with the correct data and id, in acceptance order.
